mor1kx_rf_banked: RTL and testbench
===================================

MOR1KX_RF_BANKED -- requirements
Module: mor1kx_rf_banked

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, GPR index width within one bank.
REQ-003 SHALL have parameter NUM_BANKS, default 1, shadow register sets; power of 2, range 1..16.
REQ-004 SHALL have parameter NUM_RD_PORTS, default 2, read ports; range 1..4.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1, which enables the zero-fill sequencer.
REQ-006 SHALL define BW = max(1, clog2(NUM_BANKS)) and DEPTH = NUM_BANKS * 2^ADDR_WIDTH.
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 rd_en_i  in  NUM_RD_PORTS  per-port read strobe.
REQ-010 rd_adr_i  in  NUM_RD_PORTS*ADDR_WIDTH  per-port GPR index; port p occupies slice p.
REQ-011 rd_dat_o  out  NUM_RD_PORTS*DATA_WIDTH  per-port read data.
REQ-012 wb_we_i / wb_adr_i / wb_dat_i  in  1 / ADDR_WIDTH / DATA_WIDTH  pipeline writeback to the current bank.
REQ-013 bank_switch_i / bank_sel_i  in  1 / BW  context-switch request and target bank.
REQ-014 spr_stb_i / spr_we_i  in  1 / 1  SPR access strobe and direction.
REQ-015 spr_adr_i / spr_dat_i  in  BW+ADDR_WIDTH / DATA_WIDTH  full address {bank, index} and write data.
REQ-016 spr_ack_o / spr_dat_o  out  1 / DATA_WIDTH  SPR acknowledge and read data.
REQ-017 cur_bank_o / busy_o  out  BW / 1  active bank and sequencer-busy flag.

Function
REQ-018 The FSM SHALL have two states, CLEAR and RUN. Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
REQ-019 In CLEAR, the FSM SHALL write zero to one entry per cycle, ascending from 0 to DEPTH-1, then enter RUN. CLEAR therefore lasts DEPTH cycles, with busy_o=1 throughout.
REQ-020 While busy_o=1, the block SHALL ignore wb_we_i, bank_switch_i and spr_stb_i, and SHALL hold spr_ack_o=0.
REQ-021 A writeback SHALL write wb_dat_i to entry {cur_bank, wb_adr_i}.
REQ-022 A read SHALL have a latency of 1. When rd_en_i[p]=1 in cycle N, rd_dat_o[p] in cycle N+1 SHALL equal entry {cur_bank, adr}. Write-first applies: any write to that entry in cycle N SHALL be returned.
REQ-023 When rd_en_i[p]=0, rd_dat_o[p] SHALL hold its value. If any write (wb, SPR or clear) hits the held entry, rd_dat_o[p] SHALL show the written data the next cycle.
REQ-024 The held-entry tag SHALL include the bank, so a bank switch SHALL NOT change held outputs.
REQ-025 On bank_switch_i=1 in cycle N, cur_bank_o SHALL become bank_sel_i at N+1. Reads and writebacks in cycle N SHALL use the old bank.
REQ-026 Simultaneous bank_switch_i and wb_we_i: the write SHALL go to the old bank.
REQ-027 An SPR write with wb_we_i=0 SHALL write the entry and assert spr_ack_o in the same cycle.
REQ-028 If wb_we_i=1 during an SPR write, the writeback SHALL win: no SPR write and spr_ack_o=0. The master SHALL hold its request until acked.
REQ-029 For an SPR read, spr_dat_o SHALL be registered with write-first behaviour. spr_ack_o SHALL assert in the second consecutive cycle of spr_stb_i with spr_we_i=0, with spr_dat_o valid in that cycle. After an ack, a read still strobed SHALL restart the 2-cycle count.
REQ-030 Writes to different entries in the same cycle cannot occur, because wb has priority. An SPR read and a write to the same entry in the same cycle SHALL return the new data.
REQ-031 With NUM_BANKS=1, bank_sel_i and spr_adr_i bank bits SHALL be ignored and cur_bank_o SHALL be 0.

Reset
REQ-032 On rst, the following SHALL reset: cur_bank_o=0, spr_ack_o=0, busy_o=CLEAR_ON_RESET, the clear counter to 0, and all read-hold tags invalid.
REQ-033 rd_dat_o and spr_dat_o SHALL be 0 after reset.
REQ-034 rst asserted mid-CLEAR SHALL restart clearing at entry 0.
REQ-035 Storage contents SHALL NOT be reset except via CLEAR.

Verification
REQ-036 Reset with NUM_BANKS=2, ADDR_WIDTH=5 -> busy_o=1 for exactly 64 cycles. Afterwards, a read of every {bank, index} returns 0.
REQ-037 Write r3=0xA5A5A5A5 while port0 reads r3 in the same cycle -> rd_dat_o[0]=0xA5A5A5A5 the next cycle.
REQ-038 Port1 reads r7 (value 0x11), then rd_en_i[1]=0 and a wb writes r7=0x22 -> rd_dat_o[1] changes 0x11 to 0x22 one cycle later. A later write of 0x33 to bank1 r7 leaves it at 0x22.
REQ-039 bank_switch_i=1 with bank_sel_i=1 and wb r4=0x5 in the same cycle -> bank0 r4=0x5 and cur_bank_o=1. A read of r4 afterwards returns bank1 r4.
REQ-040 SPR write {1,r9}=0xBEEF with wb_we_i=1 for 2 cycles -> spr_ack_o=0 for 2 cycles, then 1. An SPR read of {1,r9} acks on its 2nd cycle with 0xBEEF.

Source files
------------

// File: rtl/mor1kx_rf_banked.sv
// Banked GPR file with shadow register sets, write-first registered read ports,
// SPR-side access to any bank and an optional zero-fill sequencer after reset.
module mor1kx_rf_banked #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int NUM_BANKS      = 1,
  parameter int NUM_RD_PORTS   = 2,
  parameter int CLEAR_ON_RESET = 1,
  localparam int BW            = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_RD_PORTS-1:0]              rd_en_i,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0]   rd_adr_i,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rd_dat_o,
  input  logic                                 wb_we_i,
  input  logic [ADDR_WIDTH-1:0]                wb_adr_i,
  input  logic [DATA_WIDTH-1:0]                wb_dat_i,
  input  logic                                 bank_switch_i,
  input  logic [BW-1:0]                        bank_sel_i,
  input  logic                                 spr_stb_i,
  input  logic                                 spr_we_i,
  input  logic [BW+ADDR_WIDTH-1:0]             spr_adr_i,
  input  logic [DATA_WIDTH-1:0]                spr_dat_i,
  output logic                                 spr_ack_o,
  output logic [DATA_WIDTH-1:0]                spr_dat_o,
  output logic [BW-1:0]                        cur_bank_o,
  output logic                                 busy_o
);

  localparam int DEPTH = NUM_BANKS * (2 ** ADDR_WIDTH);
  localparam int MW    = $clog2(DEPTH);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                 state, state_next;
  logic [MW-1:0]          clr_cnt;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic                   run;
  logic                   we;
  logic [MW-1:0]          wa;
  logic [DATA_WIDTH-1:0]  wd;
  logic                   spr_wr_ok, spr_rd, spr_rd_phase;
  logic [MW-1:0]          spr_ent;
  logic [MW-1:0]          rd_ent [NUM_RD_PORTS];
  logic [MW-1:0]          tag    [NUM_RD_PORTS];
  logic                   tag_v  [NUM_RD_PORTS];
  logic [DATA_WIDTH-1:0]  rd_q   [NUM_RD_PORTS];

  // Single-bank builds drop the bank bits so the entry index stays in range.
  function automatic logic [MW-1:0] entry(input logic [BW-1:0] bank,
                                          input logic [ADDR_WIDTH-1:0] idx);
    logic [MW-1:0] e;
    e = MW'(idx);
    if (NUM_BANKS > 1) e[MW-1 -: BW] = bank;
    return e;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    if (state == CLEAR && clr_cnt == MW'(DEPTH - 1)) state_next = RUN;
  end

  assign busy_o    = (state == CLEAR);
  assign run       = (state == RUN) && !rst;
  assign spr_wr_ok = run && spr_stb_i && spr_we_i && !wb_we_i;
  assign spr_rd    = run && spr_stb_i && !spr_we_i;
  assign spr_ack_o = spr_wr_ok || (spr_rd && spr_rd_phase);
  assign spr_ent   = entry(spr_adr_i[BW+ADDR_WIDTH-1 -: BW], spr_adr_i[ADDR_WIDTH-1:0]);

  // One write port: clear sequencer, then writeback, then SPR write.
  always_comb begin
    we = 1'b0;
    wa = clr_cnt;
    wd = '0;
    if (state == CLEAR) begin
      we = 1'b1;
    end else if (run && wb_we_i) begin
      we = 1'b1;
      wa = entry(cur_bank_o, wb_adr_i);
      wd = wb_dat_i;
    end else if (spr_wr_ok) begin
      we = 1'b1;
      wa = spr_ent;
      wd = spr_dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk) begin
    if (rst) cur_bank_o <= '0;
    else if (run && bank_switch_i && NUM_BANKS > 1) cur_bank_o <= bank_sel_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spr_rd_phase <= 1'b0;
      spr_dat_o    <= '0;
    end else begin
      spr_rd_phase <= spr_rd && !spr_rd_phase;
      if (spr_rd) spr_dat_o <= (we && wa == spr_ent) ? wd : mem[spr_ent];
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_RD_PORTS; p++)
      rd_ent[p] = entry(cur_bank_o, rd_adr_i[p*ADDR_WIDTH +: ADDR_WIDTH]);
  end

  // Idle ports keep a tagged copy that tracks writes to the same entry.
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
      if (rst) begin
        rd_q[p]  <= '0;
        tag[p]   <= '0;
        tag_v[p] <= 1'b0;
      end else if (rd_en_i[p]) begin
        rd_q[p]  <= (we && wa == rd_ent[p]) ? wd : mem[rd_ent[p]];
        tag[p]   <= rd_ent[p];
        tag_v[p] <= 1'b1;
      end else if (tag_v[p] && we && wa == tag[p]) begin
        rd_q[p] <= wd;
      end
    end
  end

  always_comb begin
    rd_dat_o = '0;
    for (int unsigned p = 0; p < NUM_RD_PORTS; p++)
      rd_dat_o[p*DATA_WIDTH +: DATA_WIDTH] = rd_q[p];
  end

endmodule

// File: tb/tb_mor1kx_rf_banked.sv
// Self-checking bench for mor1kx_rf_banked (2 banks, 2 read ports) against a
// behavioural array model of the register file.
module tb_mor1kx_rf_banked;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_en;
  logic [9:0]  rd_adr;
  logic [63:0] rd_dat;
  logic        wb_we;
  logic [4:0]  wb_adr;
  logic [31:0] wb_dat;
  logic        bank_switch;
  logic [0:0]  bank_sel;
  logic        spr_stb, spr_we;
  logic [5:0]  spr_adr;
  logic [31:0] spr_wdat, spr_rdat;
  logic        spr_ack;
  logic [0:0]  cur_bank;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [31:0] m [64];
  int          cb;
  logic [31:0] erd [2];
  bit          tv [2];
  int          tg [2];
  bit          rph;
  logic [31:0] espr;

  always #5 clk = ~clk;

  mor1kx_rf_banked #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_BANKS(2), .NUM_RD_PORTS(2), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_en_i(rd_en), .rd_adr_i(rd_adr), .rd_dat_o(rd_dat),
    .wb_we_i(wb_we), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat),
    .bank_switch_i(bank_switch), .bank_sel_i(bank_sel),
    .spr_stb_i(spr_stb), .spr_we_i(spr_we), .spr_adr_i(spr_adr), .spr_dat_i(spr_wdat),
    .spr_ack_o(spr_ack), .spr_dat_o(spr_rdat),
    .cur_bank_o(cur_bank), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd_en = '0; rd_adr = '0; wb_we = 0; wb_adr = '0; wb_dat = '0;
    bank_switch = 0; bank_sel = '0; spr_stb = 0; spr_we = 0; spr_adr = '0; spr_wdat = '0;
  endtask

  // One RUN cycle with the inputs already applied: predict, clock, compare.
  task automatic cycle();
    bit          w, eack;
    int          wa, ra, sa;
    logic [31:0] wdv;
    #1;
    eack = 0;
    if (spr_stb) eack = spr_we ? !wb_we : rph;
    chk("spr_ack", 32'(spr_ack), 32'(eack));
    if (eack && !spr_we) chk("spr_rdat", spr_rdat, espr);
    w = 0; wa = 0; wdv = '0;
    if (wb_we) begin
      w = 1; wa = cb * 32 + int'(wb_adr); wdv = wb_dat;
    end else if (spr_stb && spr_we) begin
      w = 1; wa = int'(spr_adr); wdv = spr_wdat;
    end
    for (int p = 0; p < 2; p++) begin
      ra = cb * 32 + int'(rd_adr[p*5 +: 5]);
      if (rd_en[p]) begin
        erd[p] = (w && wa == ra) ? wdv : m[ra];
        tg[p] = ra; tv[p] = 1;
      end else if (tv[p] && w && wa == tg[p]) begin
        erd[p] = wdv;
      end
    end
    sa = int'(spr_adr);
    if (spr_stb && !spr_we) begin
      if (!rph) espr = (w && wa == sa) ? wdv : m[sa];
      rph = !rph;
    end else begin
      rph = 0;
    end
    if (w) m[wa] = wdv;
    if (bank_switch) cb = int'(bank_sel);
    @(posedge clk); #1;
    chk("rd_dat0", rd_dat[31:0], erd[0]);
    chk("rd_dat1", rd_dat[63:32], erd[1]);
    chk("cur_bank", 32'(cur_bank), 32'(cb));
    chk("busy_run", 32'(busy), 32'd0);
  endtask

  task automatic reset_and_clear(input int abort_after);
    int n;
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_bank", 32'(cur_bank), 32'd0);
    chk("rst_ack", 32'(spr_ack), 32'd0);
    chk("rst_rd0", rd_dat[31:0], 32'd0);
    chk("rst_rd1", rd_dat[63:32], 32'd0);
    chk("rst_sprdat", spr_rdat, 32'd0);
    rst = 0;
    if (abort_after > 0) begin
      repeat (abort_after) @(posedge clk);
      #1;
      chk("midclear_busy", 32'(busy), 32'd1);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
    end
    // Requests presented while clearing must all be dropped.
    wb_we = 1; wb_adr = 5'd3; wb_dat = 32'hFFFF_FFFF;
    bank_switch = 1; bank_sel = 1'b1;
    spr_stb = 1; spr_we = 1; spr_adr = 6'h23; spr_wdat = 32'hFFFF_0000;
    n = 0;
    while (busy && n < 200) begin
      #1;
      if (n % 16 == 0) chk("clear_ack", 32'(spr_ack), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    idle();
    chk("clear_len", 32'(n), 32'd64);
    chk("clear_bank", 32'(cur_bank), 32'd0);
    for (int i = 0; i < 64; i++) m[i] = '0;
    cb = 0; rph = 0; espr = '0;
    for (int p = 0; p < 2; p++) begin
      erd[p] = '0; tv[p] = 0; tg[p] = 0;
    end
  endtask

  initial begin
    reset_and_clear(0);

    for (int a = 0; a < 64; a++) begin
      idle(); spr_stb = 1; spr_adr = 6'(a);
      cycle(); cycle();
    end
    idle(); cycle();

    // Writeback and same-cycle read of r3.
    idle(); wb_we = 1; wb_adr = 5'd3; wb_dat = 32'hA5A5_A5A5; rd_en = 2'b01; rd_adr[4:0] = 5'd3;
    cycle();
    chk("r3_bypass", rd_dat[31:0], 32'hA5A5_A5A5);

    // Held port1 follows writes to r7 in its own bank only.
    idle(); wb_we = 1; wb_adr = 5'd7; wb_dat = 32'h11; cycle();
    idle(); rd_en = 2'b10; rd_adr[9:5] = 5'd7; cycle();
    chk("r7_read", rd_dat[63:32], 32'h11);
    idle(); wb_we = 1; wb_adr = 5'd7; wb_dat = 32'h22; cycle();
    chk("r7_hold_upd", rd_dat[63:32], 32'h22);
    idle(); spr_stb = 1; spr_we = 1; spr_adr = 6'h27; spr_wdat = 32'h33; cycle();
    chk("r7_other_bank", rd_dat[63:32], 32'h22);

    // Bank switch with simultaneous writeback.
    idle(); bank_switch = 1; bank_sel = 1'b1; wb_we = 1; wb_adr = 5'd4; wb_dat = 32'h5; cycle();
    chk("switch_bank", 32'(cur_bank), 32'd1);
    idle(); rd_en = 2'b01; rd_adr[4:0] = 5'd4; cycle();
    chk("bank1_r4", rd_dat[31:0], 32'd0);
    idle(); spr_stb = 1; spr_adr = 6'h04; cycle(); cycle();
    chk("bank0_r4", spr_rdat, 32'h5);

    // SPR write stalled by writebacks, then SPR read-back.
    idle(); spr_stb = 1; spr_we = 1; spr_adr = 6'h29; spr_wdat = 32'hBEEF;
    wb_we = 1; wb_adr = 5'd1; wb_dat = $urandom;
    cycle(); cycle();
    wb_we = 0; cycle();
    idle(); spr_stb = 1; spr_adr = 6'h29; cycle(); cycle();
    chk("spr_beef", spr_rdat, 32'hBEEF);
    idle(); cycle();

    for (int i = 0; i < 400; i++) begin
      rd_en       = 2'($urandom);
      rd_adr      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      wb_we       = ($urandom % 3) == 0;
      wb_adr      = 5'($urandom_range(0, 3));
      wb_dat      = $urandom;
      bank_switch = ($urandom % 8) == 0;
      bank_sel    = 1'($urandom);
      spr_stb     = 1'($urandom);
      spr_we      = 1'($urandom);
      spr_adr     = {1'($urandom), 5'($urandom_range(0, 3))};
      spr_wdat    = $urandom;
      cycle();
    end

    reset_and_clear(10);
    idle(); rd_en = 2'b11; rd_adr = {5'd2, 5'd3}; cycle();
    idle(); spr_stb = 1; spr_adr = 6'h22; cycle(); cycle();
    chk("post_clear_spr", spr_rdat, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

endmodule
